seg7_scan_driver: RTL

- Output-side counterpart to the button input conditioner: the player-facing display end of the counter UI.
- Takes the 16-bit count (4 hex/BCD nibbles) and time-multiplexes it onto a 4-digit common-anode 7-segment display.
- Captures updates only at frame boundaries, so digits never tear mid-scan.
- Sits between the counter core and the board anode/segment pins.

---
 rtl/seg7_pkg.sv | 20 ++
 rtl/seg7_hex_decode.sv | 13 +
 rtl/seg7_scan_driver.sv | 120 ++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared 7-segment constants and hex glyph table
package seg7_pkg;

    localparam int DIGITS = 4;

    typedef logic [1:0] digit_idx_t;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Active-high {g,f,e,d,c,b,a} glyphs; entry n is the pattern for hex digit n.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        return HEX_SEG[nibble];
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// rtl/seg7_hex_decode.sv - combinational hex nibble to active-high segment decoder
import seg7_pkg::*;

module seg7_hex_decode (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = hex_to_seg(nibble);
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - 4-digit multiplexed 7-segment driver; SEG7_LEADING_ZERO_BLANK_EN enables leading-zero blanking
import seg7_pkg::*;

module seg7_scan_driver #(
    parameter int REFRESH_DIV = 100000,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value,
    input  logic        load,
    input  logic [3:0]  dp,
    input  logic        blank,
    output logic [6:0]  seg,
    output logic        dp_out,
    output logic [3:0]  an,
    output logic        frame_done
);

    localparam int              PW      = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0]   PS_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [3:0]      AN_OFF  = ACTIVE_LOW ? 4'hF : 4'h0;
    localparam logic [6:0]      SEG_OFF = ACTIVE_LOW ? ~SEG_BLANK : SEG_BLANK;
    localparam logic            DP_OFF  = ACTIVE_LOW;

    logic [PW-1:0] prescaler;
    digit_idx_t    index;
    logic [15:0]   pending;
    logic          pending_valid;
    logic [15:0]   shadow;

    logic          tick;
    logic          boundary;
    logic [3:0]    nibble;
    logic [6:0]    glyph;
    logic          digit_on;
    logic [3:0]    an_sel;
    logic          dp_sel;

    assign tick       = (prescaler == PS_LAST);
    assign boundary   = tick && (index == digit_idx_t'(DIGITS - 1));
    assign frame_done = boundary;

    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler <= '0;
            index     <= '0;
        end else if (tick) begin
            prescaler <= '0;
            index     <= index + 2'd1;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    // The shadow only changes at a frame boundary; a load on that same cycle bypasses pending.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending       <= '0;
            pending_valid <= 1'b0;
            shadow        <= '0;
        end else if (boundary) begin
            if (load) begin
                shadow  <= value;
                pending <= value;
            end else if (pending_valid) begin
                shadow  <= pending;
            end
            pending_valid <= 1'b0;
        end else if (load) begin
            pending       <= value;
            pending_valid <= 1'b1;
        end
    end

    always_comb begin
        nibble = shadow[3:0];
        dp_sel = dp[0];
        an_sel = 4'b0001;
        case (index)
            2'd1: begin nibble = shadow[7:4];   dp_sel = dp[1]; an_sel = 4'b0010; end
            2'd2: begin nibble = shadow[11:8];  dp_sel = dp[2]; an_sel = 4'b0100; end
            2'd3: begin nibble = shadow[15:12]; dp_sel = dp[3]; an_sel = 4'b1000; end
            default: ;
        endcase
    end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    always_comb begin
        digit_on = 1'b1;
        case (index)
            2'd1:    digit_on = |shadow[15:4];
            2'd2:    digit_on = |shadow[15:8];
            2'd3:    digit_on = |shadow[15:12];
            default: digit_on = 1'b1;
        endcase
    end
`else
    assign digit_on = 1'b1;
`endif

    seg7_hex_decode u_decode (
        .nibble (nibble),
        .seg    (glyph)
    );

    // Polarity is applied only here, so everything upstream is active-high.
    always_ff @(posedge clk) begin
        if (reset) begin
            an     <= AN_OFF;
            seg    <= SEG_OFF;
            dp_out <= DP_OFF;
        end else begin
            an     <= (blank || !digit_on) ? AN_OFF : (an_sel ^ {4{ACTIVE_LOW}});
            seg    <= glyph ^ {7{ACTIVE_LOW}};
            dp_out <= (dp_sel && digit_on) ^ ACTIVE_LOW;
        end
    end

endmodule
